// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with valid/ready handshakes on the operand and
// result sides. AND/ADD/SUB/SLT finish in one cycle. SRL/SRA/SLL run on an
// iterative shifter that moves one bit per cycle. The result and flags are
// registered and held until the consumer accepts them.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only while IDLE)
//   x, y, op             operands and opcode; y[SHAMT_W-1:0] is the shift amount
//                        op: 000 AND, 001 ADD, 010 SUB, 011 SLT,
//                            100 SRL, 101 SRA, 110 SLL, 111 reserved
//   out_valid/out_ready  result handshake
//   z                    result
//   zero, equal          z == 0, x == y (both 0 for the reserved op)
//   overflow             signed overflow, ADD/SUB only
//   busy                 an operation is in flight (state != IDLE)
module alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             equal,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [2:0]         op_r;
  logic [SHAMT_W-1:0] cnt_r;

  logic [WIDTH-1:0]   b_s;
  logic               cin_s;
  logic [WIDTH-1:0]   low_sum_s;
  logic [1:0]         top_s;
  logic [WIDTH-1:0]   sum_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_z_s;
  logic               res_ovf_s;
  logic               flags_en_s;
  logic               is_shift_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   shifted_s;

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r != IDLE);
  assign shamt_s  = y[SHAMT_W-1:0];

  // Shared adder. SUB and SLT use x + ~y + 1. The carry into the MSB is kept
  // separate so that overflow can be formed as carry-in XOR carry-out of the MSB.
  always_comb begin
    if (op == 3'b001) begin
      b_s   = y;
      cin_s = 1'b0;
    end else begin
      b_s   = ~y;
      cin_s = 1'b1;
    end
    low_sum_s = {1'b0, x[WIDTH-2:0]} + {1'b0, b_s[WIDTH-2:0]}
              + {{(WIDTH-1){1'b0}}, cin_s};
    top_s     = {1'b0, x[WIDTH-1]} + {1'b0, b_s[WIDTH-1]}
              + {1'b0, low_sum_s[WIDTH-1]};
    sum_s     = {top_s[0], low_sum_s[WIDTH-2:0]};
    ovf_s     = low_sum_s[WIDTH-1] ^ top_s[1];
  end

  // Result selection at accept time. Shift ops load x as the shifter seed.
  always_comb begin
    res_z_s    = {WIDTH{1'b0}};
    res_ovf_s  = 1'b0;
    is_shift_s = 1'b0;
    flags_en_s = 1'b1;
    case (op)
      3'b000: res_z_s = x & y;
      3'b001, 3'b010: begin
        res_z_s   = sum_s;
        res_ovf_s = ovf_s;
      end
      3'b011: res_z_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
      3'b100, 3'b101, 3'b110: begin
        res_z_s    = x;
        is_shift_s = 1'b1;
      end
      default: begin
        res_z_s    = {WIDTH{1'b0}};
        flags_en_s = 1'b0;
      end
    endcase
  end

  // One-bit shift step. It acts on the latched opcode, so the live op input does not matter here.
  always_comb begin
    case (op_r)
      3'b100:  shifted_s = {1'b0, z[WIDTH-1:1]};
      3'b101:  shifted_s = {z[WIDTH-1], z[WIDTH-1:1]};
      3'b110:  shifted_s = {z[WIDTH-2:0], 1'b0};
      default: shifted_s = z;
    endcase
  end

  // Control FSM together with the registered result and flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 3'b000;
      cnt_r     <= SHAMT_W'(0);
      out_valid <= 1'b0;
      z         <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      equal     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            z        <= res_z_s;
            equal    <= flags_en_s & (x == y);
            overflow <= res_ovf_s;
            if (is_shift_s && (shamt_s != SHAMT_W'(0))) begin
              cnt_r   <= shamt_s;
              zero    <= 1'b0;
              state_r <= SHIFT;
            end else begin
              zero      <= flags_en_s & (res_z_s == {WIDTH{1'b0}});
              out_valid <= 1'b1;
              state_r   <= DONE;
            end
          end
        end
        SHIFT: begin
          z     <= shifted_s;
          cnt_r <= cnt_r - SHAMT_W'(1);
          // The last step: zero is taken from the final shifted value.
          if (cnt_r == SHAMT_W'(1)) begin
            zero      <= (shifted_s == {WIDTH{1'b0}});
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboarded bench for alu_iter (WIDTH=32). The driver pushes a
// hand-computed expected result for each issued op. A monitor pops and
// compares an entry on every accepted result. The driver also checks latency,
// busy/in_ready, backpressure stability and mid-operation reset.
module tb_alu_iter;
  localparam logic [2:0] OP_AND = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010,
                         OP_SLT = 3'b011, OP_SRL = 3'b100, OP_SRA = 3'b101,
                         OP_SLL = 3'b110, OP_RSV = 3'b111;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        zero, equal, overflow, busy;
  logic [31:0] x, y, z;
  logic [2:0]  op;

  typedef struct {
    logic [31:0] z;
    logic        zero;
    logic        equal;
    logic        ovf;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   next_id  = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero(zero), .equal(equal), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Monitor: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("z[%0d]", e.id),        64'(z),        64'(e.z));
        check($sformatf("zero[%0d]", e.id),     64'(zero),     64'(e.zero));
        check($sformatf("equal[%0d]", e.id),    64'(equal),    64'(e.equal));
        check($sformatf("overflow[%0d]", e.id), 64'(overflow), 64'(e.ovf));
      end
    end
  end

  // Issue one op and wait (bounded) for its result; inputs are scrambled after accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ez, input logic ezero, input logic eeq,
                       input logic eovf, input int elat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; x = a; y = b;
    q.push_back('{ez, ezero, eeq, eovf, next_id});
    next_id++;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; x = ~a; y = ~b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 80);
    check($sformatf("latency[%0d]", next_id - 1), 64'(lat), 64'(elat));
    check("busy_at_result", 64'(busy), 64'd1);
    check("in_ready_at_result", 64'(in_ready), 64'd0);
    if (out_ready) begin
      @(negedge clk);
      check("in_ready_after", 64'(in_ready), 64'd1);
      check("busy_after", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = 32'd0; y = 32'd0; op = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z",         64'(z),         64'd0);
    check("rst_flags",     64'({zero, equal, overflow}), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    //    op      x             y             z             zero  eq    ovf   lat
    issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1);
    issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    issue(OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
    issue(OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1);
    issue(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1);
    issue(OP_AND, 32'h000000A5, 32'h000000A5, 32'h000000A5, 1'b0, 1'b1, 1'b0, 1);
    issue(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
    issue(OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
    issue(OP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
    issue(OP_RSV, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
    issue(OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5);
    issue(OP_SLL, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b0, 1);
    issue(OP_SRL, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 2);
    issue(OP_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 32);
    issue(OP_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 32);
    issue(OP_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32);
    issue(OP_SLL, 32'h80000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0, 2);

    // Backpressure: result must hold while in_valid is driven with another op.
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = OP_SUB; x = 32'd9; y = 32'd9;
      @(negedge clk);
      check("bp_z",         64'(z),         64'd7);
      check("bp_flags",     64'({zero, equal, overflow}), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy",     64'(busy),     64'd0);

    // Reset in the middle of a long SRL: the op is dropped.
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_SRL; x = 32'h80000000; y = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    repeat (40) @(negedge clk);
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 1);

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
